// File: rtl/data_mem_arbiter_pkg.sv
// Shared widths, requester ids and the response record used by the DataMemory port-1 arbiter.
package data_mem_arbiter_pkg;

   localparam int BIT_WIDTH   = 64;
   localparam int MEMORY_BITS = 10;

   localparam int REQ_ID_W    = 1;
   localparam int RESP_V_W    = 1;
   localparam int RESP_RD_W   = 1;
   localparam int RESP_ERR_W  = 1;
   localparam int RESP_REC_W  = RESP_V_W + REQ_ID_W + RESP_RD_W + RESP_ERR_W;

   typedef logic [REQ_ID_W-1:0] reqId_t;

   localparam reqId_t REQ_CORE = 1'b0;
   localparam reqId_t REQ_AUX  = 1'b1;

   // One outstanding response: valid, owner, read-vs-write, out-of-range.
   typedef struct packed {
      logic   v;
      reqId_t id;
      logic   rd;
      logic   err;
   } respRec_t;

endpackage

// File: rtl/data_mem_arbiter_if.sv
// One requester's handshake bundle: request/command from the master, grant and response from the arbiter.
interface data_mem_arbiter_if #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 64
);
   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              gnt;
   logic              rvalid;
   logic [DATA_W-1:0] rdata;
   logic              err;

   modport master (
      output req, we, addr, wdata,
      input  gnt, rvalid, rdata, err
   );

   modport slave (
      input  req, we, addr, wdata,
      output gnt, rvalid, rdata, err
   );
endinterface

// File: rtl/dm_arb_starve_cnt.sv
// Saturating count of consecutive cycles requester 1 was kept waiting; at_limit flips priority.
module dm_arb_starve_cnt #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic clock,
   input  logic rst,
   input  logic inc,
   input  logic clr,
   output logic at_limit
);
   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   logic [CNT_W-1:0] waitCnt;

   always_ff @(posedge clock) begin
      if (rst) begin
         waitCnt <= '0;
      end else if (clr) begin
         waitCnt <= '0;
      end else if (inc && (waitCnt != LIMIT)) begin
         waitCnt <= waitCnt + 1'b1;
      end
   end

   assign at_limit = (waitCnt == LIMIT);
endmodule

// File: rtl/data_mem_arbiter.sv
// Shares DataMemory port 1 between the core (m0) and an auxiliary master (m1); range-checks
// each access and steers the 1-cycle registered read data back to the requester that issued it.
module data_mem_arbiter
   import data_mem_arbiter_pkg::*;
#(
   parameter int DATA_W       = BIT_WIDTH,
   parameter int ADDR_W       = BIT_WIDTH,
   parameter int MEM_BITS     = MEMORY_BITS,
   parameter int STARVE_LIMIT = 4
) (
   input  logic               clock,
   input  logic               rst,
   data_mem_arbiter_if.slave  m0,
   data_mem_arbiter_if.slave  m1,
   output logic               mem_read_en,
   output logic               mem_write_en,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic [DATA_W-1:0]  mem_wdata,
   input  logic [DATA_W-1:0]  mem_rdata
);
   // Highest byte address where a full 4-byte word still fits.
   localparam logic [MEM_BITS-1:0] LAST_WORD = MEM_BITS'((1 << MEM_BITS) - 4);

   function automatic logic addrInRange(input logic [ADDR_W-1:0] a);
      return (a[ADDR_W-1:MEM_BITS] == '0) && (a[MEM_BITS-1:0] <= LAST_WORD);
   endfunction

   logic              gnt0;
   logic              gnt1;
   logic              anyGnt;
   logic              m1Starved;
   logic              winWe;
   logic [ADDR_W-1:0] winAddr;
   logic [DATA_W-1:0] winWdata;
   logic              winInRange;
   respRec_t          resp;
   logic              respLive;
   logic [DATA_W-1:0] respData;

   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!rst) begin
         if (m1.req && (!m0.req || m1Starved)) begin
            gnt1 = 1'b1;
         end else if (m0.req) begin
            gnt0 = 1'b1;
         end
      end
   end

   assign anyGnt = gnt0 | gnt1;
   assign m0.gnt = gnt0;
   assign m1.gnt = gnt1;

   always_comb begin
      winWe    = m0.we;
      winAddr  = m0.addr;
      winWdata = m0.wdata;
      if (gnt1) begin
         winWe    = m1.we;
         winAddr  = m1.addr;
         winWdata = m1.wdata;
      end
   end

   assign winInRange = addrInRange(winAddr);

   // Out-of-range grants still show the address but never enable the memory.
   always_comb begin
      mem_read_en  = 1'b0;
      mem_write_en = 1'b0;
      mem_addr     = '0;
      mem_wdata    = '0;
      if (anyGnt) begin
         mem_addr  = winAddr;
         mem_wdata = winWdata;
         if (winInRange) begin
            mem_read_en  = !winWe;
            mem_write_en = winWe;
         end
      end
   end

   dm_arb_starve_cnt #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_starve (
      .clock    (clock),
      .rst      (rst),
      .inc      (m1.req && !gnt1),
      .clr      (gnt1 || !m1.req),
      .at_limit (m1Starved)
   );

   always_ff @(posedge clock) begin
      if (rst) begin
         resp <= '0;
      end else begin
         resp.v   <= anyGnt;
         resp.id  <= gnt1 ? REQ_AUX : REQ_CORE;
         resp.rd  <= !winWe;
         resp.err <= !winInRange;
      end
   end

   // A response left over from the cycle before reset must not surface while rst is high.
   assign respLive = resp.v && !rst;
   assign respData = (resp.rd && !resp.err) ? mem_rdata : '0;

   assign m0.rvalid = respLive && (resp.id == REQ_CORE);
   assign m1.rvalid = respLive && (resp.id == REQ_AUX);
   assign m0.err    = m0.rvalid && resp.err;
   assign m1.err    = m1.rvalid && resp.err;
   assign m0.rdata  = m0.rvalid ? respData : '0;
   assign m1.rdata  = m1.rvalid ? respData : '0;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a behavioural DataMemory and a per-cycle reference model.
module tb_data_mem_arbiter;
   import data_mem_arbiter_pkg::*;

   localparam int LIMIT = 4;

   logic        clock = 1'b0;
   logic        rst;
   logic        mem_read_en;
   logic        mem_write_en;
   logic [63:0] mem_addr;
   logic [63:0] mem_wdata;
   logic [63:0] mem_rdata = '0;

   data_mem_arbiter_if #(.DATA_W(64), .ADDR_W(64)) b0 ();
   data_mem_arbiter_if #(.DATA_W(64), .ADDR_W(64)) b1 ();

   data_mem_arbiter #(
      .DATA_W       (64),
      .ADDR_W       (64),
      .MEM_BITS     (10),
      .STARVE_LIMIT (LIMIT)
   ) dut (
      .clock        (clock),
      .rst          (rst),
      .m0           (b0),
      .m1           (b1),
      .mem_read_en  (mem_read_en),
      .mem_write_en (mem_write_en),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata)
   );

   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // DataMemory port 1: byte array, 32-bit words, registered sign-extended read.
   logic [7:0] ram [1024] = '{default: 8'h00};
   int ramIdx;
   always @(posedge clock) begin
      ramIdx = int'(mem_addr[9:0]);
      if (mem_write_en) begin
         ram[ramIdx]   <= mem_wdata[7:0];
         ram[ramIdx+1] <= mem_wdata[15:8];
         ram[ramIdx+2] <= mem_wdata[23:16];
         ram[ramIdx+3] <= mem_wdata[31:24];
      end
      if (mem_read_en) begin
         mem_rdata <= {{32{ram[ramIdx+3][7]}}, ram[ramIdx+3], ram[ramIdx+2], ram[ramIdx+1], ram[ramIdx]};
      end
   end

   // Reference model: priority rule, starvation count, pending response and a memory image.
   int          mWait = 0;
   bit          pV = 1'b0;
   bit          pId = 1'b0;
   bit          pErr = 1'b0;
   logic [63:0] pData = '0;
   logic [7:0]  img [1024] = '{default: 8'h00};

   function automatic logic [63:0] imgWord(input logic [63:0] a);
      int i;
      logic [31:0] w;
      i = int'(a[9:0]);
      w = {img[i+3], img[i+2], img[i+1], img[i]};
      return {{32{w[31]}}, w};
   endfunction

   always @(negedge clock) begin : compare
      bit          e0, e1, ok, wwe, live0, live1;
      logic [63:0] wa, wd;
      int          i;
      e0 = 1'b0;
      e1 = 1'b0;
      if (!rst) begin
         if (b1.req && (!b0.req || mWait == LIMIT)) e1 = 1'b1;
         else if (b0.req) e0 = 1'b1;
      end
      wwe = e1 ? b1.we   : b0.we;
      wa  = e1 ? b1.addr : b0.addr;
      wd  = e1 ? b1.wdata : b0.wdata;
      ok  = (e0 || e1) && (wa <= 64'd1020);

      chk("m0_gnt", b0.gnt, e0);
      chk("m1_gnt", b1.gnt, e1);
      chk("mem_read_en", mem_read_en, ok && !wwe);
      chk("mem_write_en", mem_write_en, ok && wwe);
      if (ok || !(e0 || e1)) begin
         chk("mem_addr", mem_addr, (e0 || e1) ? wa : 64'd0);
         chk("mem_wdata", mem_wdata, (e0 || e1) ? wd : 64'd0);
      end

      live0 = pV && !pId && !rst;
      live1 = pV && pId && !rst;
      chk("m0_rvalid", b0.rvalid, live0);
      chk("m1_rvalid", b1.rvalid, live1);
      chk("m0_err", b0.err, live0 && pErr);
      chk("m1_err", b1.err, live1 && pErr);
      chk("m0_rdata", b0.rdata, live0 ? pData : 64'd0);
      chk("m1_rdata", b1.rdata, live1 ? pData : 64'd0);

      if (rst) begin
         pV    = 1'b0;
         mWait = 0;
      end else begin
         pV    = e0 || e1;
         pId   = e1;
         pErr  = (e0 || e1) && !(wa <= 64'd1020);
         pData = (ok && !wwe) ? imgWord(wa) : 64'd0;
         if (ok && wwe) begin
            i = int'(wa[9:0]);
            img[i]   = wd[7:0];
            img[i+1] = wd[15:8];
            img[i+2] = wd[23:16];
            img[i+3] = wd[31:24];
         end
         if (e1 || !b1.req) mWait = 0;
         else if (mWait < LIMIT) mWait++;
      end
   end

   task automatic drive(input bit r0, input bit w0, input logic [63:0] a0, input logic [63:0] d0,
                        input bit r1, input bit w1, input logic [63:0] a1, input logic [63:0] d1);
      b0.req = r0; b0.we = w0; b0.addr = a0; b0.wdata = d0;
      b1.req = r1; b1.we = w1; b1.addr = a1; b1.wdata = d1;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic next();
      @(posedge clock);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      idle();
      next();

      // Requests held during reset get nothing.
      drive(1, 0, 8, 0, 1, 0, 0, 0);
      #3;
      chk("rst_m0_gnt", b0.gnt, 0);
      chk("rst_m1_gnt", b1.gnt, 0);
      chk("rst_rd_en", mem_read_en, 0);
      next();
      next();

      // Write then read, requester 0.
      rst = 1'b0;
      drive(1, 1, 8, 64'h8000_00F1, 0, 0, 0, 0);
      #3;
      chk("wr_m0_gnt", b0.gnt, 1);
      chk("wr_en", mem_write_en, 1);
      next();
      drive(1, 0, 8, 0, 0, 0, 0, 0);
      #3;
      chk("wack_rvalid", b0.rvalid, 1);
      chk("wack_err", b0.err, 0);
      next();
      idle();
      #3;
      chk("rd_rvalid", b0.rvalid, 1);
      chk("rd_data", b0.rdata, 64'hFFFF_FFFF_8000_00F1);
      next();

      // Lone requester 1 write, then core reads it back.
      drive(0, 0, 0, 0, 1, 1, 0, 64'h1234);
      #3;
      chk("lone_m1_gnt", b1.gnt, 1);
      chk("lone_wr_en", mem_write_en, 1);
      next();
      drive(1, 0, 0, 0, 0, 0, 0, 0);
      #3;
      chk("lone_m1_ack", b1.rvalid, 1);
      next();
      idle();
      #3;
      chk("lone_rd_data", b0.rdata, 64'h1234);
      next();

      // Continuous contention: 0,0,0,0,1 repeating.
      for (int k = 1; k <= 13; k++) begin
         drive(1, 0, 8, 0, 1, 0, 0, 0);
         #3;
         chk("cont_m1_gnt", b1.gnt, (k % 5 == 0));
         next();
      end

      // Reset with a nonzero wait count and requests held; count must restart from 0.
      rst = 1'b1;
      #3;
      chk("rst2_m0_rvalid", b0.rvalid, 0);
      next();
      next();
      rst = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         #3;
         if (k == 1) chk("rel_m0_gnt", b0.gnt, 1);
         chk("rel_m1_gnt", b1.gnt, (k == 5));
         next();
      end
      idle();
      next();

      // Range boundary with MEM_BITS=10.
      drive(1, 0, 1020, 0, 0, 0, 0, 0);
      #3;
      chk("r1020_gnt", b0.gnt, 1);
      chk("r1020_rd_en", mem_read_en, 1);
      next();
      drive(1, 0, 1021, 0, 0, 0, 0, 0);
      #3;
      chk("r1020_err", b0.err, 0);
      chk("r1021_gnt", b0.gnt, 1);
      chk("r1021_rd_en", mem_read_en, 0);
      next();
      drive(1, 0, 64'h400, 0, 0, 0, 0, 0);
      #3;
      chk("r1021_rvalid", b0.rvalid, 1);
      chk("r1021_err", b0.err, 1);
      chk("r1021_rdata", b0.rdata, 0);
      next();
      drive(1, 0, 64'h1000_0000_0000_0000, 0, 0, 0, 0, 0);
      #3;
      chk("r400_err", b0.err, 1);
      chk("r400_rdata", b0.rdata, 0);
      next();
      idle();
      #3;
      chk("rhigh_err", b0.err, 1);
      next();

      // Requester 1 read granted, then reset the next cycle: response dropped.
      drive(0, 0, 0, 0, 1, 0, 0, 0);
      #3;
      chk("pre_rst_m1_gnt", b1.gnt, 1);
      next();
      rst = 1'b1;
      idle();
      #3;
      chk("drop_m1_rvalid", b1.rvalid, 0);
      next();
      rst = 1'b0;
      next();
      next();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
